// File: rtl/dbus_uart_pkg.sv
// Shared definitions for the data-bus UART transmitter: register offsets,
// transmitter state encoding and register bit positions.
package dbus_uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_DROPS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_MSB = 12;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop happens on the same edge; flush overrides both.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [7:0]                   wdata,
  output logic [7:0]                   rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data port.
//
// state | meaning
// IDLE  | line high; pops the next byte when enabled and the FIFO holds data
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high) for CLKS_PER_BIT cycles, then back to IDLE
module dbus_uart_tx
  import dbus_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_8000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int              CW          = $clog2(FIFO_DEPTH + 1);
  localparam int              BW          = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  logic          sel;
  logic [1:0]    offset;
  logic          push_req;
  logic          ctrl_we;
  logic          flush;
  logic          drops_clr;
  logic          enable;
  logic [7:0]    drops;

  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  tx_state_e     state, state_n;
  logic [BW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;

  // Byte lanes above the low byte and the sub-word address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = &{1'b0, daddr[1:0], dwdata[31:8]};

  assign sel       = (daddr[31:4] == BASE_ADDR[31:4]);
  assign offset    = daddr[3:2];
  assign push_req  = sel && (offset == OFF_TXDATA) && dwe[0];
  assign ctrl_we   = sel && (offset == OFF_CTRL) && dwe[0];
  assign flush     = ctrl_we && dwdata[CTRL_FLUSH];
  assign drops_clr = sel && (offset == OFF_DROPS) && (dwe != 4'b0000);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .flush (flush),
    .wdata (dwdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Enable bit; flush is a pulse derived from the write itself and never stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        enable <= 1'b1;
    else if (ctrl_we) enable <= dwdata[CTRL_ENABLE];
  end

  // Saturating count of pushes lost to a full FIFO; a same-edge pop makes room.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drops <= 8'd0;
    else if (drops_clr)
      drops <= 8'd0;
    else if (push_req && fifo_full && !fifo_pop && !flush && (drops != 8'hFF))
      drops <= drops + 8'd1;
  end

  // Transmitter state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  // Next-state logic; tx is computed one cycle ahead so the line is a flop output.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tx_n       = tx;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (enable && !fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_n    = fifo_rdata;
          baud_cnt_n = BAUD_RELOAD;
          state_n    = START;
          tx_n       = 1'b0;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          state_n    = DATA;
          bit_cnt_n  = 3'd0;
          baud_cnt_n = BAUD_RELOAD;
          tx_n       = shift[0];
        end else begin
          baud_cnt_n = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_cnt_n = BAUD_RELOAD;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
          end
        end else begin
          baud_cnt_n = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == '0) state_n = IDLE;
        else                baud_cnt_n = baud_cnt - 1'b1;
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // Transmit-done interrupt, registered from the current FIFO and FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b1;
    else       irq <= fifo_empty && (state == IDLE);
  end

  // Combinational read mux; unselected or write-only locations return zero.
  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (offset)
        OFF_STATUS: begin
          rdata[STAT_BUSY]  = (state != IDLE);
          rdata[STAT_FULL]  = fifo_full;
          rdata[STAT_EMPTY] = fifo_empty;
          rdata[STAT_COUNT_MSB:STAT_COUNT_LSB] = 5'(fifo_count);
        end
        OFF_CTRL:  rdata[CTRL_ENABLE] = enable;
        OFF_DROPS: rdata[7:0]         = drops;
        default:   rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Directed bench for dbus_uart_tx: bus writes push expected bytes into a
// scoreboard, a serial monitor decodes tx frames and pops/compares them.
`timescale 1ns/1ps
module tb_dbus_uart_tx;

  localparam int          CPB   = 16;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] daddr = 32'd0;
  logic [31:0] dwdata = 32'd0;
  logic [3:0]  dwe = 4'd0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int         n_assert = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         mon_en = 1'b1;
  logic [7:0] sb[$];
  int         starts[$];

  dbus_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dwe    (dwe),
    .rdata  (rdata),
    .tx     (tx),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write commits on the following rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    daddr  = a;
    dwdata = d;
    dwe    = be;
    @(negedge clk);
    dwe    = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    daddr = a;
    #1;
    d = rdata;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  // Serial monitor: samples mid-bit on falling edges and checks each frame.
  initial begin : monitor
    logic [7:0] b;
    logic       ok_start;
    logic       ok_stop;
    int         t0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && mon_en) begin
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        ok_start = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        ok_stop = (tx === 1'b1);
        if (mon_en) begin
          starts.push_back(t0);
          chk("start_bit", {31'd0, ok_start}, 32'd1);
          chk("stop_bit", {31'd0, ok_stop}, 32'd1);
          chk("unexpected_frame", {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) chk("frame_byte", {24'd0, b}, {24'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [31:0] r;
    int          bad;
    logic        irq_mid;

    // Reset asserted and held: outputs take reset values without a clock edge.
    #1 reset = 1'b1;
    #1;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset.
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || irq !== 1'b1) bad++;
    end
    chk("idle_tx_irq", bad, 0);
    rd(BASE + 32'h4, r);  chk("status_after_reset", r, 32'h0000_0004);
    rd(BASE + 32'h8, r);  chk("ctrl_after_reset", r, 32'h0000_0001);
    rd(32'h0000_9004, r); chk("outside_window", r, 32'h0);
    @(negedge clk);
    rd(BASE + 32'hC, r);  chk("drops_after_reset", r, 32'h0);
    rd(BASE + 32'h0, r);  chk("txdata_reads_zero", r, 32'h0);
    @(negedge clk);
    wr(BASE, 32'h55, 4'b0000);
    wr(BASE, 32'h55, 4'b0010);
    rd(BASE + 32'h4, r);  chk("status_after_ignored_writes", r, 32'h0000_0004);

    // Single byte 0xA5: latency, busy throughout, irq low then high.
    @(negedge clk);
    sb.push_back(8'hA5);
    wr(BASE, 32'h0000_00A5, 4'b0001);
    chk("latency_tx_still_high", {31'd0, tx}, 32'd1);
    @(negedge clk);
    chk("latency_tx_low", {31'd0, tx}, 32'd0);
    rd(BASE + 32'h4, r);  chk("status_in_frame", r, 32'h0000_0005);
    bad = 0;
    irq_mid = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      rd(BASE + 32'h4, r);
      if (r[0] !== 1'b1) bad++;
      if (k == FRAME / 2) irq_mid = irq;
    end
    chk("busy_whole_frame", bad, 0);
    chk("irq_low_in_frame", {31'd0, irq_mid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("irq_after_frame", {31'd0, irq}, 32'd1);
    rd(BASE + 32'h4, r);  chk("status_after_frame", r, 32'h0000_0004);
    chk("sb_after_a5", sb.size(), 0);

    // Fill with enable off: nine writes, the ninth is dropped.
    @(negedge clk);
    wr(BASE + 32'h8, 32'h0, 4'b0001);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sb.push_back(8'(8'h11 + i));
      wr(BASE, 32'(32'h11 + i), 4'b1111);
    end
    rd(BASE + 32'h4, r);  chk("status_full", r, 32'h0000_0802);
    rd(BASE + 32'hC, r);  chk("drops_one", r, 32'h0000_0001);
    chk("irq_with_data", {31'd0, irq}, 32'd0);
    chk("tx_idle_disabled", {31'd0, tx}, 32'd1);

    // Enable, then push on the same edge as the first pop of a full FIFO.
    @(negedge clk);
    starts.delete();
    wr(BASE + 32'h8, 32'h1, 4'b0001);
    sb.push_back(8'h77);
    wr(BASE, 32'h77, 4'b0001);
    rd(BASE + 32'h4, r);  chk("status_push_on_pop", r, 32'h0000_0803);
    rd(BASE + 32'hC, r);  chk("drops_push_on_pop", r, 32'h0000_0001);
    wait_drain(9 * (FRAME + 1) + 40);
    repeat (CPB) @(negedge clk);
    chk("frame_count", starts.size(), 9);
    bad = 0;
    for (int i = 1; i < starts.size(); i++)
      if (starts[i] - starts[i-1] != FRAME + 1) bad++;
    chk("frame_spacing", bad, 0);
    wr(BASE + 32'hC, 32'h0, 4'b0100);
    rd(BASE + 32'hC, r);  chk("drops_cleared", r, 32'h0);
    rd(BASE + 32'h4, r);  chk("status_drained", r, 32'h0000_0004);

    // Reset in the middle of 0x5A's first data bit with three bytes queued.
    @(negedge clk);
    mon_en = 1'b0;
    wr(BASE, 32'h5A, 4'b0001);
    wr(BASE, 32'h01, 4'b0001);
    wr(BASE, 32'h02, 4'b0001);
    wr(BASE, 32'h03, 4'b0001);
    repeat (18) @(negedge clk);
    rd(BASE + 32'h4, r);  chk("status_before_reset", r, 32'h0000_0301);
    chk("tx_bit0_before_reset", {31'd0, tx}, 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("tx_on_async_reset", {31'd0, tx}, 32'd1);
    chk("irq_on_async_reset", {31'd0, irq}, 32'd1);
    rd(BASE + 32'h4, r);  chk("status_on_async_reset", r, 32'h0000_0004);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("no_frames_after_reset", bad, 0);
    rd(BASE + 32'h4, r);  chk("status_after_reset_release", r, 32'h0000_0004);
    rd(BASE + 32'h8, r);  chk("ctrl_after_reset_release", r, 32'h0000_0001);
    @(negedge clk);
    mon_en = 1'b1;

    // Flush mid-frame with four queued: the frame in flight still completes.
    sb.push_back(8'h3C);
    wr(BASE, 32'h3C, 4'b0001);
    for (int i = 0; i < 4; i++) wr(BASE, 32'(32'h41 + i), 4'b0001);
    rd(BASE + 32'h4, r);  chk("status_four_queued", r, 32'h0000_0401);
    repeat (30) @(negedge clk);
    wr(BASE + 32'h8, 32'h3, 4'b0001);
    rd(BASE + 32'h4, r);  chk("status_after_flush", r, 32'h0000_0005);
    rd(BASE + 32'h8, r);  chk("ctrl_after_flush", r, 32'h0000_0001);
    rd(BASE + 32'hC, r);  chk("drops_after_flush", r, 32'h0);
    @(negedge clk);
    wait_drain(FRAME + 40);
    repeat (3 * FRAME) @(negedge clk);
    chk("tx_idle_after_flush", {31'd0, tx}, 32'd1);
    chk("irq_after_flush", {31'd0, irq}, 32'd1);
    rd(BASE + 32'h4, r);  chk("status_end", r, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
